multicycle_control: RTL and testbench

Control sequencer for the multi-cycle revision of the MIPS datapath. The datapath shares one memory for instruction and data, one ALU for PC increment, branch target and execute, and has IR/A/B/ALUOut holding registers. This block walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives every datapath mux and write enable. It stalls on a memory ready handshake, counts retired instructions, and halts on an illegal opcode.

---
 rtl/multicycle_control_pkg.sv | 57 +++++
 rtl/multicycle_control_output_decode.sv | 70 +++++++
 rtl/multicycle_control.sv | 106 ++++++++++
 tb/tb_multicycle_control.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// datapath mux selects and the packed control vector.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Combinational state-to-control decode; only FETCH looks at mem_ready so the
// PC and IR load exactly once, on the cycle the fetch read completes.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: next-state register, retired-instruction
// counter and sticky halt flag; control decode lives in mc_output_decode.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic                    mem_ready,
  output logic                    PCWrite,
  output logic                    PCWriteCond,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    MemtoReg,
  output logic                    RegDst,
  output logic                    RegWrite,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              PCSource,
  output logic [CNT_WIDTH-1:0]    retired,
  output logic                    halted
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 halted_q;
  logic                 retire;
  ctrl_t                ctrl, ctrl_g;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (Opcode == OPCODE_WIDTH'(OP_LW) || Opcode == OPCODE_WIDTH'(OP_SW))
          state_d = S_MEMADR;
        else if (Opcode == OPCODE_WIDTH'(OP_RTYPE)) state_d = S_EXEC;
        else if (Opcode == OPCODE_WIDTH'(OP_BEQ))   state_d = S_BRANCH;
        else if (Opcode == OPCODE_WIDTH'(OP_J))     state_d = S_JUMP;
        else if (Opcode == OPCODE_WIDTH'(OP_ADDI))  state_d = S_ADDI_EX;
        else                                        state_d = S_HALT;
      end
      S_MEMADR: state_d = (Opcode == OPCODE_WIDTH'(OP_SW)) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:    state_d = S_RWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + 1'b1;
      if (state_d == S_HALT) halted_q <= 1'b1;
    end
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Reset lands in FETCH, which requests a read; mask so nothing is driven during reset.
  assign ctrl_g = rst ? ctrl : '0;

  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.iord;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign IRWrite     = ctrl_g.ir_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign RegDst      = ctrl_g.reg_dst;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign ALUOp       = ctrl_g.alu_op;
  assign PCSource    = ctrl_g.pc_source;
  assign retired     = retired_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle table of {Opcode, mem_ready,
// expected control vector, expected retired} plus halt and mid-op reset sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  Opcode = '0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, halted;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] retired;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .retired(retired), .halted(halted)
  );

  // Vector bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA | ALUSrcB ALUOp PCSource | halted
  localparam logic [16:0] VF1   = 17'b1001010000_010000_0;
  localparam logic [16:0] VF0   = 17'b0001000000_010000_0;
  localparam logic [16:0] VDEC  = 17'b0000000000_110000_0;
  localparam logic [16:0] VMADR = 17'b0000000001_100000_0;
  localparam logic [16:0] VMRD  = 17'b0011000000_000000_0;
  localparam logic [16:0] VMWB  = 17'b0000001010_000000_0;
  localparam logic [16:0] VMWR  = 17'b0010100000_000000_0;
  localparam logic [16:0] VEXEC = 17'b0000000001_001000_0;
  localparam logic [16:0] VRWB  = 17'b0000000110_000000_0;
  localparam logic [16:0] VBR   = 17'b0100000001_000101_0;
  localparam logic [16:0] VJ    = 17'b1000000000_000010_0;
  localparam logic [16:0] VAEX  = 17'b0000000001_100000_0;
  localparam logic [16:0] VAWB  = 17'b0000000010_000000_0;
  localparam logic [16:0] VHALT = 17'b0000000000_000000_1;
  localparam logic [16:0] VZERO = 17'b0000000000_000000_0;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [16:0] exp_vec;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] act_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance to the next negedge.
  task automatic apply(input string name, input logic [5:0] op, input logic rdy,
                       input logic [16:0] ev, input logic [31:0] er);
    Opcode    = op;
    mem_ready = rdy;
    #1;
    check({name, " ctrl"}, {15'd0, act_vec()}, {15'd0, ev});
    check({name, " retired"}, retired, er);
    $display("[TB] %s op=%b rdy=%0d ctrl=%b retired=%0d", name, op, rdy, act_vec(), retired);
    @(negedge clk);
  endtask

  function automatic void add(input logic [5:0] op, input logic rdy,
                              input logic [16:0] ev, input logic [31:0] er);
    vecs.push_back('{op, rdy, ev, er});
  endfunction

  initial begin
    // R-type, with mem_ready low where it must be ignored
    add(6'h00, 1, VF1, 0);   add(6'h00, 0, VDEC, 0);
    add(6'h00, 0, VEXEC, 0); add(6'h00, 1, VRWB, 0);
    // lw with two MEMRD stalls
    add(6'h00, 1, VF1, 1);   add(6'h23, 1, VDEC, 1);  add(6'h23, 1, VMADR, 1);
    add(6'h23, 0, VMRD, 1);  add(6'h23, 0, VMRD, 1);  add(6'h23, 1, VMRD, 1);
    add(6'h23, 0, VMWB, 1);
    // three FETCH stalls, then beq
    add(6'h00, 0, VF0, 2);   add(6'h00, 0, VF0, 2);   add(6'h00, 0, VF0, 2);
    add(6'h00, 1, VF1, 2);   add(6'h04, 1, VDEC, 2);  add(6'h04, 1, VBR, 2);
    // j
    add(6'h00, 1, VF1, 3);   add(6'h02, 1, VDEC, 3);  add(6'h02, 1, VJ, 3);
    // addi
    add(6'h00, 1, VF1, 4);   add(6'h08, 1, VDEC, 4);  add(6'h08, 1, VAEX, 4);
    add(6'h08, 1, VAWB, 4);
    // sw with one MEMWR stall
    add(6'h00, 1, VF1, 5);   add(6'h2B, 1, VDEC, 5);  add(6'h2B, 1, VMADR, 5);
    add(6'h2B, 0, VMWR, 5);  add(6'h2B, 1, VMWR, 5);
    // illegal opcode
    add(6'h00, 1, VF1, 6);   add(6'h3F, 1, VDEC, 6);  add(6'h3F, 1, VHALT, 6);

    // reset state
    #2;
    check("reset ctrl", {15'd0, act_vec()}, 32'd0);
    check("reset retired", retired, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].rdy, vecs[i].exp_vec, vecs[i].exp_ret);
    end

    // HALT holds for 20 more cycles regardless of inputs
    for (int i = 0; i < 20; i++) begin
      apply($sformatf("halt%0d", i), 6'(i), 1'b1, VHALT, 32'd6);
    end

    // Only reset leaves HALT
    rst = 1'b0;
    #1;
    check("halt reset ctrl", {15'd0, act_vec()}, {15'd0, VZERO});
    @(negedge clk);
    rst = 1'b1;
    apply("post-halt fetch", 6'h00, 1'b1, VF1, 32'd0);
    apply("r2 decode", 6'h00, 1'b1, VDEC, 32'd0);
    apply("r2 exec", 6'h00, 1'b1, VEXEC, 32'd0);
    apply("r2 rwb", 6'h00, 1'b1, VRWB, 32'd0);
    apply("sw2 fetch", 6'h00, 1'b1, VF1, 32'd1);
    apply("sw2 decode", 6'h2B, 1'b1, VDEC, 32'd1);
    apply("sw2 memadr", 6'h2B, 1'b1, VMADR, 32'd1);

    // Reset asserted mid-cycle while MEMWR is stalled
    Opcode    = 6'h2B;
    mem_ready = 1'b0;
    #1;
    check("memwr before reset", {15'd0, act_vec()}, {15'd0, VMWR});
    #1;
    rst = 1'b0;
    #1;
    check("memwr reset MemWrite", {31'd0, MemWrite}, 32'd0);
    check("memwr reset ctrl", {15'd0, act_vec()}, {15'd0, VZERO});
    check("memwr reset retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply("after reset fetch", 6'h00, 1'b0, VF0, 32'd0);
    apply("after reset fetch2", 6'h00, 1'b1, VF1, 32'd0);
    apply("after reset decode", 6'h00, 1'b1, VDEC, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
